// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encodings for the serial arithmetic units
package serial_adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'b00;
    localparam state_t BUSY = 2'b01;
    localparam state_t DONE = 2'b10;

endpackage

// File: rtl/serial_adder_full_adder.sv
// rtl/serial_adder_full_adder.sv - single-bit full adder used by the serial datapath
module serial_adder_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial add/subtract, one bit per clock, LSB first
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;
    logic             fa_sum;
    logic             fa_cout;

    serial_adder_full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == LAST_BIT);
    assign sum_next = {fa_sum, sum_sh};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // carry still holds the carry into the MSB while the last bit is processed
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= op_a;
                        b_sh  <= op_b ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_next[WIDTH-1:1];
                    carry  <= fa_cout;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        result    <= sum_next;
                        carry_out <= fa_cout;
                        overflow  <= carry ^ fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 sub  input  1  0 = add, 1 = subtract (op_a - op_b); sampled with start.
REQ-006 op_a  input  WIDTH  first operand; sampled with start.
REQ-007 op_b  input  WIDTH  second operand; sampled with start.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse; result, carry_out and overflow are valid from this cycle.
REQ-010 result  output  WIDTH  sum or difference, two's complement, modulo 2^WIDTH.
REQ-011 carry_out  output  1  carry out of bit WIDTH-1 (for sub: 1 = no borrow).
REQ-012 overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-013 The block SHALL compute the result bit-serially through exactly one Full_adder instance, one bit per clock, LSB first.
REQ-014 FSM states SHALL be IDLE, BUSY, DONE; IDLE->BUSY on start; BUSY->DONE after bit WIDTH-1; DONE->IDLE unconditionally after one cycle.
REQ-015 On accepting start, the block SHALL latch op_a, op_b XOR {WIDTH{sub}}, set the carry register to sub, and clear the bit counter.
REQ-016 In BUSY, each cycle SHALL feed operand LSBs and the carry register to the Full_adder, shift sum into the result register MSB, shift operands right, store carry, and increment the counter.
REQ-017 Bit i SHALL be processed at the (i+1)-th rising edge after the start-sampling edge; done SHALL be high for the cycle following edge WIDTH, i.e. latency WIDTH cycles.
REQ-018 The carry into bit WIDTH-1 SHALL be retained to form overflow at the final bit.
REQ-019 start asserted in BUSY or DONE SHALL be ignored, with no effect on the current operation or on later behaviour.
REQ-020 result, carry_out and overflow SHALL update only at the end of the final bit and hold their values until the next accepted start completes.
REQ-021 done SHALL never be asserted in two consecutive cycles.
REQ-022 start held high continuously SHALL launch back-to-back operations: the next start is accepted in the first IDLE cycle after DONE.

Reset
REQ-023 Reset SHALL force IDLE, busy=0, done=0, result=0, carry_out=0, overflow=0, and counter, carry and operand registers to 0.
REQ-024 Reset asserted mid-operation SHALL abort it at the next edge; no done pulse SHALL follow, and the previous result SHALL not be preserved.
REQ-025 Reset SHALL take priority over start in the same cycle.

Structure
REQ-026 The state encodings (IDLE=2'b00, BUSY=2'b01, DONE=2'b10) SHALL be localparams in a shared include under src/common/, reused by later serial units.
REQ-027 The counter width SHALL be $clog2(WIDTH) bits, derived from WIDTH.
REQ-028 The existing Full_adder SHALL be the only sub-module; there SHALL be no other arithmetic operators on the datapath.

Verification (WIDTH=8)
REQ-029 Add 0x03+0x05 -> done exactly 8 cycles after the start edge; result=0x08, carry_out=0, overflow=0; busy high for 9 cycles (8 BUSY + 1 DONE).
REQ-030 Add 0xFF+0x01 -> result=0x00, carry_out=1, overflow=0; add 0x7F+0x01 -> result=0x80, carry_out=0, overflow=1.
REQ-031 Sub 0x05-0x07 -> result=0xFE, carry_out=0; sub 0x80-0x01 -> result=0x7F, overflow=1.
REQ-032 Pulse start with 0x10+0x20 mid-operation of 0x01+0x01 -> single done pulse, result=0x02; second request not executed.
REQ-033 Assert reset at bit 4 of 0x0F+0x0F -> all outputs 0 next cycle, no done pulse; a fresh start then yields 0x1E.
REQ-034 Hold start high with fixed operands 0x11+0x22 -> done pulses every 10 cycles, each with result=0x33.
